pong_match_ctrl: RTL and testbench



---
 rtl/pong_pkg.sv | 35 +++
 rtl/pong_tick_gen.sv | 32 +++
 rtl/pong_match_ctrl.sv | 154 +++++++++++++++
 tb/tb_pong_match_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------
// pong_pkg : shared codes for the pong match sequencer
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SERVE    = 2'd1,
    ST_PLAY     = 2'd2,
    ST_GAMEOVER = 2'd3
  } fsm_e;

  localparam logic [1:0] GOAL_NONE    = 2'b00;
  localparam logic [1:0] GOAL_ILLEGAL = 2'b01;
  localparam logic [1:0] GOAL_RWALL   = 2'b10;
  localparam logic [1:0] GOAL_LWALL   = 2'b11;

  localparam logic [1:0] ADV_RAND  = 2'b00;
  localparam logic [1:0] ADV_RIGHT = 2'b10;
  localparam logic [1:0] ADV_LEFT  = 2'b11;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? 4'hF : s + 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pong_tick_gen.sv
// ---------------------------------------------------------------
// pong_tick_gen : free-running divider, one-cycle tick at wrap
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module pong_tick_gen #(
  parameter int TICK_DIV = 220000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/pong_match_ctrl.sv
// ---------------------------------------------------------------
// pong_match_ctrl : serve timing, scoring and winner detection
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int TICK_DIV    = 220000,
  parameter int SERVE_TICKS = 250,
  parameter int WIN_SCORE   = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] goal,
  output logic       state,
  output logic [1:0] adv,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [1:0] winner,
  output logic       serving,
  output logic [1:0] fsm
);

  localparam int SC_W = (SERVE_TICKS > 0) ? $clog2(SERVE_TICKS + 1) : 1;
  localparam logic [SC_W-1:0] SERVE_LOAD = SC_W'(SERVE_TICKS);
  localparam logic [3:0]      WIN_VAL    = 4'(WIN_SCORE);

  logic tick;

  pong_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  fsm_e            fsm_q, fsm_d;
  logic            sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [1:0]      g1_q, g1_d, g2_q, g2_d;
  logic [SC_W-1:0] serve_cnt_q, serve_cnt_d;
  logic [3:0]      score_l_q, score_l_d, score_r_q, score_r_d;
  logic [1:0]      adv_q, adv_d, winner_q, winner_d;
  logic [3:0]      inc_score;
  logic            start_evt, goal_evt;

  always_comb begin
    sync1_d     = start;
    sync2_d     = sync1_q;
    sync3_d     = sync2_q;
    g1_d        = goal;
    g2_d        = g1_q;
    fsm_d       = fsm_q;
    serve_cnt_d = serve_cnt_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    adv_d       = adv_q;
    winner_d    = winner_q;
    inc_score   = '0;

    start_evt = sync2_q & ~sync3_q;
    // Only the first cycle of a non-zero, legal code counts; 01 never does.
    goal_evt  = (g1_q != GOAL_NONE) && (g1_q != GOAL_ILLEGAL) &&
                (g2_q == GOAL_NONE) && (fsm_q == ST_PLAY);

    case (fsm_q)
      ST_IDLE: begin
        if (start_evt) begin
          fsm_d       = ST_SERVE;
          serve_cnt_d = SERVE_LOAD;
          adv_d       = ADV_RAND;
        end
      end
      ST_SERVE: begin
        if (tick) begin
          // <= 1 also covers a zero-length serve delay
          if (serve_cnt_q <= SC_W'(1)) fsm_d = ST_PLAY;
          else                         serve_cnt_d = serve_cnt_q - SC_W'(1);
        end
      end
      ST_PLAY: begin
        if (goal_evt) begin
          if (g1_q == GOAL_LWALL) begin
            inc_score = sat_inc(score_r_q);
            score_r_d = inc_score;
            adv_d     = ADV_LEFT;
          end else begin
            inc_score = sat_inc(score_l_q);
            score_l_d = inc_score;
            adv_d     = ADV_RIGHT;
          end
          if (inc_score == WIN_VAL) begin
            fsm_d    = ST_GAMEOVER;
            winner_d = (g1_q == GOAL_LWALL) ? WIN_RIGHT : WIN_LEFT;
          end else begin
            fsm_d       = ST_SERVE;
            serve_cnt_d = SERVE_LOAD;
          end
        end
      end
      ST_GAMEOVER: begin
        if (start_evt) begin
          fsm_d       = ST_SERVE;
          serve_cnt_d = SERVE_LOAD;
          score_l_d   = '0;
          score_r_d   = '0;
          winner_d    = WIN_NONE;
          adv_d       = ADV_RAND;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= ST_IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      g1_q        <= GOAL_NONE;
      g2_q        <= GOAL_NONE;
      serve_cnt_q <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      adv_q       <= ADV_RAND;
      winner_q    <= WIN_NONE;
    end else begin
      fsm_q       <= fsm_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      g1_q        <= g1_d;
      g2_q        <= g2_d;
      serve_cnt_q <= serve_cnt_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      adv_q       <= adv_d;
      winner_q    <= winner_d;
    end
  end

  assign state       = (fsm_q == ST_PLAY);
  assign serving     = (fsm_q == ST_SERVE);
  assign fsm         = fsm_q;
  assign adv         = adv_q;
  assign score_left  = score_l_q;
  assign score_right = score_r_q;
  assign winner      = winner_q;

endmodule

`default_nettype wire

// File: tb/tb_pong_match_ctrl.sv
// ---------------------------------------------------------------
// tb_pong_match_ctrl : directed bench for pong_match_ctrl
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_pong_match_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] goal;
  logic       state;
  logic [1:0] adv;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic [1:0] winner;
  logic       serving;
  logic [1:0] fsm;

  int n_checks = 0;
  int n_errors = 0;

  pong_match_ctrl #(
    .TICK_DIV    (4),
    .SERVE_TICKS (3),
    .WIN_SCORE   (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .goal        (goal),
    .state       (state),
    .adv         (adv),
    .score_left  (score_left),
    .score_right (score_right),
    .winner      (winner),
    .serving     (serving),
    .fsm         (fsm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_fsm(input logic [1:0] tgt, input int budget, input string tag);
    for (int i = 0; i < budget && fsm !== tgt; i++) step();
    check(tag, {30'd0, fsm}, {30'd0, tgt});
  endtask

  task automatic score_goal(input logic [1:0] code);
    goal = code;
    steps(2);
    goal = 2'b00;
    step();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    goal  = 2'b00;
    steps(3);
    rst = 1'b0;
    steps(20);
    check("idle_state",  state,       0);
    check("idle_fsm",    fsm,         0);
    check("idle_sl",     score_left,  0);
    check("idle_sr",     score_right, 0);
    check("idle_adv",    adv,         0);
    check("idle_winner", winner,      0);
    check("idle_serving", serving,    0);

    start = 1'b1;
    wait_fsm(2'd1, 3, "start_to_serve");
    check("serve_serving", serving, 1);
    check("serve_state",   state,   0);
    start = 1'b0;
    wait_fsm(2'd2, 16, "serve_to_play");
    check("play_state", state, 1);
    check("play_adv",   adv,   0);

    // Left wall breach held 10 cycles: right scores once, serve toward left.
    goal = 2'b11;
    step();
    check("goal_lat1_sr", score_right, 0);
    step();
    check("goal_lat2_sr",  score_right, 1);
    check("goal_lat2_adv", adv,         2'b11);
    check("goal_lat2_fsm", fsm,         1);
    check("goal_lat2_st",  state,       0);
    steps(8);
    goal = 2'b00;
    wait_fsm(2'd2, 16, "replay_after_hold");
    steps(2);
    check("no_double_sr", score_right, 1);
    check("no_double_sl", score_left,  0);

    goal = 2'b01;
    steps(3);
    goal = 2'b00;
    steps(2);
    check("illegal_sl",  score_left,  0);
    check("illegal_sr",  score_right, 1);
    check("illegal_fsm", fsm,         2);

    score_goal(2'b10);
    check("left1_sl",  score_left, 1);
    check("left1_adv", adv,        2'b10);
    check("left1_fsm", fsm,        1);
    goal = 2'b10;
    steps(2);
    goal = 2'b00;
    step();
    check("serve_goal_sl",  score_left, 1);
    check("serve_goal_fsm", fsm,        1);

    wait_fsm(2'd2, 16, "play_left2");
    score_goal(2'b10);
    check("left2_sl", score_left, 2);
    wait_fsm(2'd2, 16, "play_left3");
    score_goal(2'b10);
    check("win_sl",     score_left, 3);
    check("win_winner", winner,     2'b01);
    check("win_fsm",    fsm,        3);
    check("win_state",  state,      0);
    score_goal(2'b11);
    steps(2);
    check("over_frozen_sr",  score_right, 1);
    check("over_frozen_fsm", fsm,         3);
    check("over_frozen_win", winner,      2'b01);

    start = 1'b1;
    wait_fsm(2'd1, 4, "restart_serve");
    start = 1'b0;
    check("restart_sl",  score_left,  0);
    check("restart_sr",  score_right, 0);
    check("restart_win", winner,      0);
    check("restart_adv", adv,         0);

    wait_fsm(2'd2, 16, "r_play1");
    score_goal(2'b10);
    wait_fsm(2'd2, 16, "r_play2");
    score_goal(2'b10);
    wait_fsm(2'd2, 16, "r_play3");
    score_goal(2'b11);
    wait_fsm(2'd2, 16, "r_play4");
    check("pre_rst_sl", score_left,  2);
    check("pre_rst_sr", score_right, 1);

    // Goal captured by the first sync stage, then an asynchronous reset mid-cycle.
    goal = 2'b11;
    step();
    #2;
    rst = 1'b1;
    #1;
    check("rst_fsm",     fsm,         0);
    check("rst_state",   state,       0);
    check("rst_adv",     adv,         0);
    check("rst_sl",      score_left,  0);
    check("rst_sr",      score_right, 0);
    check("rst_winner",  winner,      0);
    check("rst_serving", serving,     0);
    #2;
    rst  = 1'b0;
    goal = 2'b00;
    steps(3);
    check("post_rst_sr",  score_right, 0);
    check("post_rst_fsm", fsm,         0);
    start = 1'b1;
    wait_fsm(2'd1, 4, "post_rst_serve");
    start = 1'b0;
    check("post_rst_sl2", score_left,  0);
    check("post_rst_sr2", score_right, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
